// File: rtl/exu_div_seq_pkg.sv
// Shared types and sizing for the sequential integer divider.
// XLEN and the instruction-tag width are set here for the whole core slice.
package exu_div_seq_pkg;

    localparam int XLEN     = 32;
    localparam int TAG_W    = 4;
    localparam int DIV_ITER = XLEN;
    localparam int CNT_W    = $clog2(XLEN) + 1;

    localparam logic [XLEN-1:0] SGN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } div_state_e;

    // Two's-complement magnitude of a value that is known to be negative when neg=1.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/exu_div_seq.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// sign fix-up afterwards, and an optional bypass for divide-by-zero and signed overflow.
module exu_div_seq
    import exu_div_seq_pkg::*;
#(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [XLEN-1:0]  issue_rs1_data,
    input  logic [XLEN-1:0]  issue_rs2_data,
    input  logic [4:0]       issue_rd_addr,
    input  logic             issue_signed,
    input  logic             issue_rem,
    input  logic [TAG_W-1:0] issue_instr_tag,
    output logic             div_busy,
    output logic [XLEN-1:0]  wb_data,
    output logic [4:0]       wb_rd_addr,
    output logic             wb_rd_wr_en,
    output logic [TAG_W-1:0] wb_instr_tag
);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvs_q;
    logic [4:0]       rd_q;
    logic [TAG_W-1:0] tag_q;
    logic             rem_sel_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic             accept;
    logic             rs1_neg;
    logic             rs2_neg;
    logic             dvs_zero;
    logic             sgn_ovf;
    logic             early;
    logic [XLEN-1:0]  early_res;
    logic [XLEN-1:0]  fix_res;
    logic [XLEN:0]    r_shift;
    logic [XLEN:0]    r_diff;

    assign accept   = issue_valid && !flush && (state == IDLE || state == DONE);
    assign div_busy = accept || state == CALC || state == FIXUP;

    assign rs1_neg  = issue_signed && issue_rs1_data[XLEN-1];
    assign rs2_neg  = issue_signed && issue_rs2_data[XLEN-1];
    assign dvs_zero = (issue_rs2_data == '0);
    assign sgn_ovf  = issue_signed && issue_rs1_data == SGN_MIN && issue_rs2_data == '1;
    assign early    = EARLY_OUT && (dvs_zero || sgn_ovf);

    // Partial remainder gets one extra bit so the trial subtraction's sign is exact.
    assign r_shift = {rem_q, quo_q[XLEN-1]};
    assign r_diff  = r_shift - {1'b0, dvs_q};

    always_comb begin
        // NOTE: give every always_comb output a value on entry so no path infers a latch.
        early_res = '0;
        fix_res   = neg_quo_q ? -quo_q : quo_q;
        if (dvs_zero) begin
            early_res = issue_rem ? issue_rs1_data : '1;
        end else if (!issue_rem) begin
            early_res = SGN_MIN;
        end
        if (rem_sel_q) begin
            fix_res = neg_rem_q ? -rem_q : rem_q;
        end
    end

    // NOTE: clocked state uses <= only, so every reader sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too so the writeback bus reads 0 after reset.
            state        <= IDLE;
            cnt          <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            rd_q         <= '0;
            tag_q        <= '0;
            rem_sel_q    <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            wb_data      <= '0;
            wb_rd_addr   <= '0;
            wb_rd_wr_en  <= 1'b0;
            wb_instr_tag <= '0;
        end else begin
            wb_rd_wr_en <= 1'b0;
            if (flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (issue_valid) begin
                            quo_q     <= mag(issue_rs1_data, rs1_neg);
                            dvs_q     <= mag(issue_rs2_data, rs2_neg);
                            rem_q     <= '0;
                            rd_q      <= issue_rd_addr;
                            tag_q     <= issue_instr_tag;
                            rem_sel_q <= issue_rem;
                            // A zero divisor keeps the all-ones quotient unsigned-looking.
                            neg_quo_q <= (rs1_neg ^ rs2_neg) && !dvs_zero;
                            neg_rem_q <= rs1_neg;
                            cnt       <= '0;
                            if (early) begin
                                state        <= DONE;
                                wb_data      <= early_res;
                                wb_rd_addr   <= issue_rd_addr;
                                wb_instr_tag <= issue_instr_tag;
                                wb_rd_wr_en  <= (issue_rd_addr != 5'd0);
                            end else begin
                                state <= CALC;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    CALC: begin
                        if (!r_diff[XLEN]) begin
                            rem_q <= r_diff[XLEN-1:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_q <= r_shift[XLEN-1:0];
                            quo_q <= {quo_q[XLEN-2:0], 1'b0};
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DIV_ITER - 1)) begin
                            state <= FIXUP;
                        end
                    end
                    FIXUP: begin
                        state        <= DONE;
                        wb_data      <= fix_res;
                        wb_rd_addr   <= rd_q;
                        wb_instr_tag <= tag_q;
                        wb_rd_wr_en  <= (rd_q != 5'd0);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exu_div_seq.sv
// Directed bench for exu_div_seq: latency, signed fix-up, early-out bypass,
// flush, rd=0 suppression and asynchronous reset, with an EARLY_OUT=0 twin.
module tb_exu_div_seq;
    import exu_div_seq_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             issue_valid;
    logic [XLEN-1:0]  issue_rs1_data;
    logic [XLEN-1:0]  issue_rs2_data;
    logic [4:0]       issue_rd_addr;
    logic             issue_signed;
    logic             issue_rem;
    logic [TAG_W-1:0] issue_instr_tag;

    logic             div_busy;
    logic [XLEN-1:0]  wb_data;
    logic [4:0]       wb_rd_addr;
    logic             wb_rd_wr_en;
    logic [TAG_W-1:0] wb_instr_tag;

    logic             e0_div_busy;
    logic [XLEN-1:0]  e0_wb_data;
    logic [4:0]       e0_wb_rd_addr;
    logic             e0_wb_rd_wr_en;
    logic [TAG_W-1:0] e0_wb_instr_tag;

    int checks   = 0;
    int failures = 0;
    int wc;
    int bc;

    exu_div_seq #(.EARLY_OUT(1'b1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .issue_valid     (issue_valid),
        .issue_rs1_data  (issue_rs1_data),
        .issue_rs2_data  (issue_rs2_data),
        .issue_rd_addr   (issue_rd_addr),
        .issue_signed    (issue_signed),
        .issue_rem       (issue_rem),
        .issue_instr_tag (issue_instr_tag),
        .div_busy        (div_busy),
        .wb_data         (wb_data),
        .wb_rd_addr      (wb_rd_addr),
        .wb_rd_wr_en     (wb_rd_wr_en),
        .wb_instr_tag    (wb_instr_tag)
    );

    exu_div_seq #(.EARLY_OUT(1'b0)) dut_e0 (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .issue_valid     (issue_valid),
        .issue_rs1_data  (issue_rs1_data),
        .issue_rs2_data  (issue_rs2_data),
        .issue_rd_addr   (issue_rd_addr),
        .issue_signed    (issue_signed),
        .issue_rem       (issue_rem),
        .issue_instr_tag (issue_instr_tag),
        .div_busy        (e0_div_busy),
        .wb_data         (e0_wb_data),
        .wb_rd_addr      (e0_wb_rd_addr),
        .wb_rd_wr_en     (e0_wb_rd_wr_en),
        .wb_instr_tag    (e0_wb_instr_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic sgn, input logic rem, input logic [TAG_W-1:0] tag);
        issue_rs1_data  = a;
        issue_rs2_data  = b;
        issue_rd_addr   = rd;
        issue_signed    = sgn;
        issue_rem       = rem;
        issue_instr_tag = tag;
        issue_valid     = 1'b1;
        #1;
    endtask

    // Step cycles from 'start' until a strobe is seen or 'limit' passes; wb_cyc=-1 on timeout.
    task automatic run_to_wb(input int start, input int limit, output int wb_cyc, output int busy_cnt);
        int c;
        c        = start;
        wb_cyc   = -1;
        busy_cnt = 0;
        while (c <= limit && wb_cyc < 0) begin
            if (wb_rd_wr_en) begin
                wb_cyc = c;
            end else begin
                if (div_busy) busy_cnt++;
                tick();
                c++;
            end
        end
    endtask

    // Bypass case on the EARLY_OUT=1 DUT, same result at normal latency on the twin.
    task automatic early_case(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic sgn, input logic rem,
                              input logic [TAG_W-1:0] tag, input logic [31:0] exp);
        issue(a, b, rd, sgn, rem, tag);
        check({name, "_busy_c0"}, div_busy, 1);
        tick();
        issue_valid = 1'b0;
        check({name, "_strobe_c1"}, wb_rd_wr_en, 1);
        check({name, "_data"}, wb_data, exp);
        check({name, "_tag"}, wb_instr_tag, tag);
        check({name, "_e0_busy_c1"}, e0_div_busy, 1);
        repeat (33) tick();
        check({name, "_no_strobe_c34"}, wb_rd_wr_en, 0);
        check({name, "_e0_strobe_c34"}, e0_wb_rd_wr_en, 1);
        check({name, "_e0_data"}, e0_wb_data, exp);
        tick();
    endtask

    initial begin
        rst_n           = 1'b0;
        flush           = 1'b0;
        issue_valid     = 1'b0;
        issue_rs1_data  = '0;
        issue_rs2_data  = '0;
        issue_rd_addr   = '0;
        issue_signed    = 1'b0;
        issue_rem       = 1'b0;
        issue_instr_tag = '0;
        #2;
        check("rst_busy", div_busy, 0);
        check("rst_wen", wb_rd_wr_en, 0);
        check("rst_data", wb_data, 0);
        check("rst_rd", wb_rd_addr, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // DIVU 100/7 -> 14, strobe at cycle 34, busy cycles 0..33
        issue(32'd100, 32'd7, 5'd5, 1'b0, 1'b0, 4'h3);
        check("divu_busy_c0", div_busy, 1);
        tick();
        issue_valid = 1'b0;
        run_to_wb(1, 40, wc, bc);
        check("divu_wb_cycle", wc, 34);
        check("divu_busy_cycles", bc, 33);
        check("divu_data", wb_data, 32'd14);
        check("divu_rd", wb_rd_addr, 5);
        check("divu_tag", wb_instr_tag, 4'h3);
        check("divu_busy_done", div_busy, 0);
        check("divu_e0_data", e0_wb_data, 32'd14);
        tick();
        check("divu_strobe_one_cycle", wb_rd_wr_en, 0);
        check("divu_data_held", wb_data, 32'd14);
        tick();

        // REM -7 % 2 -> -1, then DIV -7 / 2 issued in the DONE cycle -> -3
        issue(32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, 1'b1, 4'h4);
        tick();
        issue_valid = 1'b0;
        run_to_wb(1, 40, wc, bc);
        check("rem_wb_cycle", wc, 34);
        check("rem_data", wb_data, 32'hFFFF_FFFF);
        issue(32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1, 1'b0, 4'h5);
        check("b2b_busy_accept", div_busy, 1);
        tick();
        issue_valid = 1'b0;
        check("b2b_strobe_dropped", wb_rd_wr_en, 0);
        run_to_wb(1, 40, wc, bc);
        check("b2b_wb_cycle", wc, 34);
        check("b2b_data", wb_data, 32'hFFFF_FFFD);
        check("b2b_rd", wb_rd_addr, 7);
        tick();

        // Full-width unsigned dividend exercises the extra remainder bit
        issue(32'hFFFF_FFFF, 32'd3, 5'd8, 1'b0, 1'b0, 4'h6);
        tick();
        issue_valid = 1'b0;
        run_to_wb(1, 40, wc, bc);
        check("divu_big_data", wb_data, 32'h5555_5555);
        tick();

        early_case("div0",   32'd5,        32'd0,        5'd9,  1'b1, 1'b0, 4'h7, 32'hFFFF_FFFF);
        early_case("remu0",  32'd5,        32'd0,        5'd10, 1'b0, 1'b1, 4'h8, 32'd5);
        early_case("divovf", 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1, 1'b0, 4'h9, 32'h8000_0000);
        early_case("removf", 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1, 1'b1, 4'h2, 32'd0);

        // Flush at cycle 10 of the operation
        issue(32'd100, 32'd7, 5'd13, 1'b0, 1'b0, 4'h1);
        tick();
        issue_valid = 1'b0;
        repeat (9) tick();
        check("flush_busy_c10", div_busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy_c11", div_busy, 0);
        run_to_wb(11, 50, wc, bc);
        check("flush_no_wb", wc, -1);
        check("flush_idle_busy", bc, 0);

        // Flush together with issue_valid: nothing accepted
        flush = 1'b1;
        issue(32'd100, 32'd7, 5'd14, 1'b0, 1'b0, 4'h1);
        check("flush_issue_busy", div_busy, 0);
        tick();
        issue_valid = 1'b0;
        flush       = 1'b0;
        run_to_wb(1, 40, wc, bc);
        check("flush_issue_no_wb", wc, -1);
        check("flush_issue_no_busy", bc, 0);

        // rd = 0: full operation, no strobe
        issue(32'd100, 32'd7, 5'd0, 1'b0, 1'b0, 4'hA);
        tick();
        issue_valid = 1'b0;
        run_to_wb(1, 40, wc, bc);
        check("rd0_no_wb", wc, -1);
        check("rd0_busy_cycles", bc, 33);

        // Reset at cycle 15 of an operation
        issue(32'hFFFF_FFFF, 32'd3, 5'd15, 1'b0, 1'b0, 4'hB);
        tick();
        issue_valid = 1'b0;
        repeat (14) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", div_busy, 0);
        check("rst_mid_data", wb_data, 0);
        check("rst_mid_tag", wb_instr_tag, 0);
        check("rst_mid_wen", wb_rd_wr_en, 0);
        #2;
        rst_n = 1'b1;
        tick();
        run_to_wb(16, 60, wc, bc);
        check("rst_mid_no_wb", wc, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exu_div_seq.md
EXU_DIV_SEQ -- requirements
Module: exu_div_seq

Interface
REQ-001 Parameter: EARLY_OUT, default 1, 1 = divide-by-zero and signed-overflow bypass the iteration loop.
REQ-002 Port: clk  input  1  core clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: flush  input  1  pipe flush, aborts any operation.
REQ-005 Port: issue_valid  input  1  IDU1 issues a legal div/rem.
REQ-006 Port: issue_rs1_data  input  XLEN  dividend.
REQ-007 Port: issue_rs2_data  input  XLEN  divisor.
REQ-008 Port: issue_rd_addr  input  5  destination register.
REQ-009 Port: issue_signed  input  1  1 = DIV/REM, 0 = DIVU/REMU.
REQ-010 Port: issue_rem  input  1  1 = return remainder, 0 = quotient.
REQ-011 Port: issue_instr_tag  input  tag width from types  instruction tag.
REQ-012 Port: div_busy  output  1  drives IDU1 exu_div_busy.
REQ-013 Port: wb_data  output  XLEN  result.
REQ-014 Port: wb_rd_addr  output  5  result destination.
REQ-015 Port: wb_rd_wr_en  output  1  one-cycle writeback strobe.
REQ-016 Port: wb_instr_tag  output  tag width  tag of written-back instruction.

Function
REQ-017 States SHALL be IDLE, CALC, FIXUP, DONE.
REQ-018 Issue SHALL be accepted only when state is IDLE or DONE and flush=0; otherwise issue_valid SHALL be ignored.
REQ-019 On accept, operands, rd, tag, signed, rem SHALL be captured; signed operands converted to magnitude; next state CALC with iteration counter = 0.
REQ-020 CALC SHALL perform one radix-2 restoring step per cycle, exactly XLEN cycles, then go to FIXUP.
REQ-021 FIXUP SHALL negate quotient if operand signs differ (signed only) and negate remainder if dividend negative (signed only), then go to DONE.
REQ-022 DONE SHALL last exactly one cycle with wb_rd_wr_en=1 (unless rd=0), then IDLE, or CALC/DONE if a new issue is accepted that cycle.
REQ-023 Normal latency: accept edge at cycle 0, wb_rd_wr_en high in cycle XLEN+2 (34 for XLEN=32).
REQ-024 Divisor zero (EARLY_OUT=1): go directly to DONE; quotient = all ones, remainder = dividend; wb in cycle 1.
REQ-025 Signed overflow (dividend 0x80000000, divisor -1, EARLY_OUT=1): direct to DONE; quotient = 0x80000000, remainder = 0.
REQ-026 With EARLY_OUT=0 the same results SHALL emerge from the normal loop at normal latency.
REQ-027 rd_addr = 0: full operation runs, wb_rd_wr_en SHALL stay 0.
REQ-028 div_busy SHALL be 1 when issue_valid is accepted (combinational) and in CALC and FIXUP; 0 in IDLE and DONE without new issue.
REQ-029 flush SHALL force IDLE on next edge, suppress any pending/same-cycle wb, and win over simultaneous issue_valid.
REQ-030 wb_data, wb_rd_addr, wb_instr_tag SHALL be registered and held stable outside DONE; wb_rd_wr_en is the only qualifier.

Reset
REQ-031 On rst_n=0: state IDLE, counter 0, div_busy 0, wb_rd_wr_en 0, wb_data 0, wb_rd_addr 0, wb_instr_tag 0, all datapath registers 0.
REQ-032 Reset mid-operation SHALL abandon the operation without writeback.

Structure
REQ-033 Enum div_state_e and constant DIV_ITER = XLEN SHALL live in the shared types package; XLEN from global.
REQ-034 No sub-module; datapath and FSM in one module, counter width clog2(XLEN)+1.

Verification
REQ-035 DIVU 100/7, rd=5 -> wb_data 14, wb_rd_addr 5, strobe in cycle 34, busy high cycles 0-33.
REQ-036 REM signed -7 % 2 -> 0xFFFFFFFF; DIV signed -7/2 -> 0xFFFFFFFD.
REQ-037 DIV 5/0 -> 0xFFFFFFFF cycle 1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-038 flush at cycle 10 of CALC -> no strobe, div_busy 0 from cycle 11; flush with issue_valid -> nothing accepted.
REQ-039 rd=0 divide -> no strobe at cycle 34; back-to-back issue in DONE -> second result at cycle 34 after its accept.
REQ-040 rst_n low at cycle 15 -> all outputs 0, no strobe afterwards.
